clock_divider_ctrl: RTL and testbench

// - Run-time controller for the CPU clock divider. Holds the active divisor.
// - Accepts new divisors over a valid/ready handshake and applies them only at half-period boundaries.
// - Starts and stops the divided clock without glitches, and issues a one-cycle enable on each divided rising edge.
// - Sits between the debug/config front end and the Forth CPU core's clock-enable input.

---
 rtl/clock_divider_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clock_divider_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_ctrl.sv
// Run-time divisor/start-stop controller for the CPU clock divider.
// Optional single-step support: define CLOCK_DIVIDER_CTRL_STEP_EN.
module clock_divider_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_div_valid,
    output logic             o_div_ready,
    output logic [WIDTH-1:0] o_div_active,
    output logic             o_clk,
    output logic             o_clk_en,
    output logic             o_running,
    output logic [1:0]       o_state
);

    // Handshake: a divisor transfers on any edge where i_div_valid && o_div_ready;
    // o_div_ready stays low while a divisor is pending and returns after it is applied.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
`ifdef CLOCK_DIVIDER_CTRL_STEP_EN
        , S_STEP   = 2'd3
`endif
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] div_q, div_n;
    logic [WIDTH-1:0] pend_q, pend_n;
    logic             pv_q, pv_n;
    logic             clk_q, clk_n;
    logic             en_q, en_n;
    logic             boundary;
    logic             adv;

`ifndef CLOCK_DIVIDER_CTRL_STEP_EN
    logic step_unused;
    assign step_unused = i_step;
`endif

    assign boundary = (cnt_q == div_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= WIDTH'(DEFAULT_DIV);
            pend_q  <= '0;
            pv_q    <= 1'b0;
            clk_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            div_q   <= div_n;
            pend_q  <= pend_n;
            pv_q    <= pv_n;
            clk_q   <= clk_n;
            en_q    <= en_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        div_n   = div_q;
        pend_n  = pend_q;
        pv_n    = pv_q;
        clk_n   = clk_q;
        en_n    = 1'b0;
        adv     = 1'b0;

        if (i_div_valid && !pv_q) begin
            pend_n = i_div;
            pv_n   = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_n = '0;
                clk_n = 1'b0;
                if (pv_q) begin
                    div_n = pend_q;
                    pv_n  = 1'b0;
                end
                if (i_run) begin
                    state_n = S_RUN;
                end
`ifdef CLOCK_DIVIDER_CTRL_STEP_EN
                else if (i_step) begin
                    // Step starts with the rising edge so the period is rise-then-fall.
                    state_n = S_STEP;
                    clk_n   = 1'b1;
                    en_n    = 1'b1;
                end
`endif
            end
            S_RUN: begin
                if (!i_run && !clk_q) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    adv = 1'b1;
                    if (!i_run) begin
                        state_n = boundary ? S_IDLE : S_STOPPING;
                    end
                end
            end
            S_STOPPING: begin
                adv = 1'b1;
                if (i_run) begin
                    state_n = S_RUN;
                end else if (boundary) begin
                    state_n = S_IDLE;
                end
            end
`ifdef CLOCK_DIVIDER_CTRL_STEP_EN
            S_STEP: begin
                if (boundary) begin
                    cnt_n = '0;
                    clk_n = 1'b0;
                    if (pv_q) begin
                        div_n = pend_q;
                        pv_n  = 1'b0;
                    end
                    if (!clk_q) begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + WIDTH'(1);
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Free-running half-period count; a pending divisor takes over at the boundary.
        if (adv) begin
            if (boundary) begin
                cnt_n = '0;
                clk_n = ~clk_q;
                en_n  = ~clk_q;
                if (pv_q) begin
                    div_n = pend_q;
                    pv_n  = 1'b0;
                end
            end else begin
                cnt_n = cnt_q + WIDTH'(1);
            end
        end
    end

    assign o_div_ready  = ~pv_q;
    assign o_div_active = div_q;
    assign o_clk        = clk_q;
    assign o_clk_en     = en_q;
    assign o_state      = state_q;
`ifdef CLOCK_DIVIDER_CTRL_STEP_EN
    assign o_running    = (state_q == S_RUN) || (state_q == S_STEP);
`else
    assign o_running    = (state_q == S_RUN);
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Self-checking bench for clock_divider_ctrl: per-cycle {o_clk, o_clk_en} scoreboard
// plus direct checks of handshake, divisor and reset behaviour.
module tb_clock_divider_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             div_valid = 1'b0;
    logic             div_ready;
    logic [WIDTH-1:0] div_active;
    logic             dclk;
    logic             dclk_en;
    logic             running;
    logic [1:0]       state;

    logic [1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    clock_divider_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (run),
        .i_step       (step),
        .i_div        (div_in),
        .i_div_valid  (div_valid),
        .o_div_ready  (div_ready),
        .o_div_active (div_active),
        .o_clk        (dclk),
        .o_clk_en     (dclk_en),
        .o_running    (running),
        .o_state      (state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Push n cycles of level lvl; first entry carries the enable when rise is set.
    task automatic push_run(input logic lvl, input int n, input logic rise);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({lvl, (i == 0) ? rise : 1'b0});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag);
        logic [1:0] e;
        tick();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        check(tag, {30'd0, dclk, dclk_en}, {30'd0, e});
    endtask

    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step_chk(tag);
        end
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_clk", dclk, 1'b0);
        check("rst_en", dclk_en, 1'b0);
        check("rst_ready", div_ready, 1'b1);
        check("rst_div", div_active, 16'd2);
        check("rst_running", running, 1'b0);
        check("rst_state", state, 2'd0);

        // default divisor 2: first rise 3 edges after entering RUN, period 6
        run = 1'b1;
        push_run(1'b0, 3, 1'b0);
        push_run(1'b1, 3, 1'b1);
        push_run(1'b0, 3, 1'b0);
        push_run(1'b1, 3, 1'b1);
        push_run(1'b0, 3, 1'b0);
        drain("div2_wave");
        check("div2_active", div_active, 16'd2);
        check("div2_running", running, 1'b1);

        // divisor 0 accepted mid-high-phase: high completes at 3 cycles, then period 2
        push_run(1'b1, 3, 1'b1);
        push_run(1'b0, 1, 1'b0);
        push_run(1'b1, 1, 1'b1);
        push_run(1'b0, 1, 1'b0);
        push_run(1'b1, 1, 1'b1);
        push_run(1'b0, 1, 1'b0);
        step_chk("chg_wave");
        div_in = 16'd0;
        div_valid = 1'b1;
        step_chk("chg_wave");
        div_valid = 1'b0;
        check("chg_ready_lo1", div_ready, 1'b0);
        step_chk("chg_wave");
        check("chg_ready_lo2", div_ready, 1'b0);
        check("chg_old_div", div_active, 16'd2);
        step_chk("chg_wave");
        check("chg_ready_hi", div_ready, 1'b1);
        check("chg_new_div", div_active, 16'd0);
        drain("chg_wave");

        // transfer on a boundary edge: next half uses old div 0, the one after uses 3
        push_run(1'b1, 1, 1'b1);
        push_run(1'b0, 4, 1'b0);
        push_run(1'b1, 4, 1'b1);
        push_run(1'b0, 4, 1'b0);
        div_in = 16'd3;
        div_valid = 1'b1;
        step_chk("bnd_wave");
        div_valid = 1'b0;
        check("bnd_div_old", div_active, 16'd0);
        step_chk("bnd_wave");
        check("bnd_div_new", div_active, 16'd3);
        drain("bnd_wave");

        // stop while high at counter 0: high phase finishes, then no more pulses
        push_run(1'b1, 4, 1'b1);
        push_run(1'b0, 6, 1'b0);
        step_chk("stop_wave");
        run = 1'b0;
        drain("stop_wave");
        check("stop_running", running, 1'b0);
        check("stop_state", state, 2'd0);

        // divisor load while idle applies on the next edge
        div_in = 16'd1;
        div_valid = 1'b1;
        tick();
        div_valid = 1'b0;
        check("idle_ready_lo", div_ready, 1'b0);
        tick();
        check("idle_div", div_active, 16'd1);
        check("idle_ready_hi", div_ready, 1'b1);

        // single step at div 1
`ifdef CLOCK_DIVIDER_CTRL_STEP_EN
        push_run(1'b1, 2, 1'b1);
        push_run(1'b0, 4, 1'b0);
`else
        push_run(1'b0, 6, 1'b0);
`endif
        step = 1'b1;
        step_chk("step_wave");
        step = 1'b0;
        drain("step_wave");
        check("step_state", state, 2'd0);
        check("step_running", running, 1'b0);

        // async reset mid-high-phase with a divisor pending
        run = 1'b1;
        push_run(1'b0, 2, 1'b0);
        push_run(1'b1, 2, 1'b1);
        step_chk("rst2_wave");
        step_chk("rst2_wave");
        step_chk("rst2_wave");
        div_in = 16'd5;
        div_valid = 1'b1;
        step_chk("rst2_wave");
        div_valid = 1'b0;
        run = 1'b0;
        check("rst2_ready_lo", div_ready, 1'b0);
        check("rst2_clk_hi", dclk, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst2_async_clk", dclk, 1'b0);
        check("rst2_async_en", dclk_en, 1'b0);
        #1 rst = 1'b0;
        check("rst2_ready", div_ready, 1'b1);
        check("rst2_div", div_active, 16'd2);
        push_run(1'b0, 4, 1'b0);
        drain("rst2_after");
        check("rst2_no_pend", div_active, 16'd2);
        check("rst2_state", state, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
